// File: rtl/demux_stream_1xn.sv
// 1-to-N streaming demux with per-channel one-entry holding registers, valid/ready
// handshake, round-robin mode and out-of-range drop. Optional DEMUX_STREAM_CNT_EN adds xfer_cnt.
module demux_stream_ch #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_fill,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);
  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // Fill wins over drain so a same-cycle drain+fill keeps the slot occupied.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_fill) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

module demux_stream_1xn #(
  parameter int N_CH   = 16,
  parameter int SEL_W  = 4,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel_in,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_ready,
  output logic [N_CH-1:0]        out_valid,
  output logic [N_CH*DATA_W-1:0] out_data,
  input  logic [N_CH-1:0]        out_ready,
  output logic [SEL_W-1:0]       rr_ptr,
  output logic                   err_sel
`ifdef DEMUX_STREAM_CNT_EN
  ,
  output logic [15:0]            xfer_cnt
`endif
);
  localparam logic [SEL_W:0]   LP_NCH  = (SEL_W+1)'(N_CH);
  localparam logic [SEL_W-1:0] LP_LAST = SEL_W'(N_CH-1);

  logic [SEL_W-1:0]             w_tgt;
  logic                         w_tgt_ok;
  logic [N_CH-1:0]              w_hit;
  logic [N_CH-1:0]              w_fill;
  logic                         w_acc;
  logic [N_CH-1:0][DATA_W-1:0]  w_data;
  logic [SEL_W-1:0]             r_rr_ptr;
  logic                         r_err_sel;

  assign w_tgt    = mode ? r_rr_ptr : sel_in;
  assign w_tgt_ok = {1'b0, w_tgt} < LP_NCH;
  // Out-of-range beats are always accepted so they can be dropped without stalling.
  assign in_ready = w_tgt_ok ? |(w_hit & (~out_valid | out_ready)) : 1'b1;
  assign w_acc    = in_valid & in_ready;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign w_hit[k]  = (w_tgt == SEL_W'(k));
    assign w_fill[k] = w_acc & w_hit[k];

    demux_stream_ch #(.DATA_W(DATA_W)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .i_fill  (w_fill[k]),
      .i_data  (in_data),
      .i_ready (out_ready[k]),
      .o_valid (out_valid[k]),
      .o_data  (w_data[k])
    );
  end

  assign out_data = w_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr  <= '0;
      r_err_sel <= 1'b0;
    end else begin
      r_err_sel <= w_acc & ~w_tgt_ok;
      if (mode && w_acc)
        r_rr_ptr <= (r_rr_ptr == LP_LAST) ? '0 : r_rr_ptr + 1'b1;
    end
  end

  assign rr_ptr  = r_rr_ptr;
  assign err_sel = r_err_sel;

`ifdef DEMUX_STREAM_CNT_EN
  logic [15:0] r_xfer_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_xfer_cnt <= '0;
    else if (w_acc && w_tgt_ok && r_xfer_cnt != 16'hFFFF)
      r_xfer_cnt <= r_xfer_cnt + 16'd1;
  end

  assign xfer_cnt = r_xfer_cnt;
`endif
endmodule

// File: doc/demux_stream_1xn.md
Name: demux_stream_1xn

Overview:
Parametrised 1-to-N streaming demultiplexer. Successor to the combinational 1x16 demux. Adds per-channel output registers, a valid/ready handshake, a round-robin distribution mode and out-of-range select detection. Sits between a single producer stream and N channel consumers in the wireless datapath.

Parameters:
N_CH, 16, number of output channels (2..16)
SEL_W, 4, select width; N_CH <= 2**SEL_W
DATA_W, 8, payload width per beat

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
mode  input  1  0 = select-directed, 1 = round-robin
sel_in  input  SEL_W  target channel in select-directed mode
in_valid  input  1  producer beat valid
in_data  input  DATA_W  producer payload
in_ready  output  1  block accepts beat this cycle
out_valid  output  N_CH  per-channel valid, bit k = channel k
out_data  output  N_CH*DATA_W  per-channel payload, channel k at [k*DATA_W +: DATA_W]
out_ready  input  N_CH  per-channel consumer ready
rr_ptr  output  SEL_W  current round-robin pointer
err_sel  output  1  one-cycle pulse: out-of-range beat dropped

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high. On reset: out_valid=0, out_data=0, rr_ptr=0, err_sel=0, and xfer_cnt=0 when the optional feature is compiled in.
- Target channel: tgt = mode ? rr_ptr : sel_in. tgt is combinational; a mode change takes effect in the same cycle.
- Each channel has a one-entry holding register: valid bit plus DATA_W payload.
- Valid target (tgt < N_CH): in_ready = !out_valid[tgt] | out_ready[tgt]. Drain and fill in the same cycle is allowed, so throughput is 1 beat/cycle.
- Invalid target (tgt >= N_CH, select-directed mode only): in_ready=1. The beat is accepted and discarded. err_sel=1 on the next cycle for exactly one cycle. No channel state changes.
- Accept means in_valid & in_ready. On accept to a valid target, out_data[tgt] and out_valid[tgt] are set on the next edge. Latency is 1 cycle.
- Drain: when out_valid[k] & out_ready[k] and there is no fill to k in the same cycle, out_valid[k] clears on the next edge. out_data[k] holds its last value.
- Simultaneous drain and fill of k: out_valid[k] stays 1 and out_data[k] takes the new beat.
- Stability: while out_valid[k] & !out_ready[k], out_data[k] does not change.
- Channels are independent. Backpressure on one channel never stalls a beat targeting another channel.
- Round-robin: rr_ptr advances by 1 on each accepted beat while mode=1. It wraps from N_CH-1 to 0. rr_ptr is never >= N_CH.
- If the channel at rr_ptr is full and not draining, in_ready=0 and rr_ptr holds; the pointer does not skip the stalled channel.
- While mode=0, rr_ptr holds its value.
- in_valid=0: no state change except drains.
- Reset mid-operation discards all held beats. No beat is emitted on the cycle after reset.

Optional Feature:
Macro DEMUX_STREAM_CNT_EN.
- When defined: adds output port xfer_cnt[15:0]. It counts beats accepted to valid targets. Dropped beats are not counted. It saturates at 16'hFFFF and clears on rst.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Select-directed, N_CH=16: mode=0, sel_in=9, in_data=8'hA5, in_valid=1 for 1 cycle, out_ready=0 -> next cycle out_valid=16'h0200 and channel 9 data=8'hA5; held stable for 5 cycles; out_ready[9]=1 -> out_valid=0 on the following cycle.
- Backpressure isolation: channel 1 full with out_ready[1]=0; send sel_in=1 -> in_ready=0. Send sel_in=4, data 8'h3C -> accepted; out_valid[4]=1 with data 8'h3C one cycle later.
- Round-robin wrap, N_CH=4: mode=1, 6 beats 8'h10..8'h15 with all out_ready=1 -> channels 0,1,2,3,0,1 receive them in order; rr_ptr ends at 2.
- Out-of-range, N_CH=12: mode=0, sel_in=15, data 8'hFF -> in_ready=1, err_sel high for exactly 1 cycle, out_valid unchanged, xfer_cnt unchanged.
- Full throughput on one channel: sel_in=3, 8 back-to-back beats with out_ready[3]=1 -> in_ready stays 1 throughout; 8 outputs in order; xfer_cnt=8.
- Reset mid-stream: assert rst with channels 0 and 5 holding data -> next cycle out_valid=0, rr_ptr=0, err_sel=0, xfer_cnt=0.
